// File: rtl/alu_operand_regfile.sv
// Register file, busy scoreboard and single-entry operand slot feeding the ALU.
// Same-cycle writebacks are bypassed into the issued operands and clear busy before the hazard check.
module alu_operand_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [AW-1:0]   iss_rs1_addr,
    input  logic [AW-1:0]   iss_rs2_addr,
    input  logic [AW-1:0]   iss_rd_addr,
    input  logic            iss_rd_we,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [AW-1:0]   op_rd_addr,
    output logic            op_rd_we,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t                state;
    logic [XLEN-1:0]      regs [NREG];
    logic [NREG-1:0]      busy;
    logic [NREG-1:0]      wb_clr;
    logic [NREG-1:0]      eff_busy;
    logic [XLEN-1:0]      rd1_val;
    logic [XLEN-1:0]      rd2_val;
    logic                 hazard;
    logic                 slot_free;
    logic                 accept;

    assign op_valid = (state == FULL);

    always_comb begin
        wb_clr = '0;
        if (wb_valid) begin
            wb_clr[wb_addr] = 1'b1;
        end
    end

    assign eff_busy  = busy & ~wb_clr;
    assign hazard    = (iss_rd_we && eff_busy[iss_rd_addr])
                     || eff_busy[iss_rs1_addr] || eff_busy[iss_rs2_addr];
    assign slot_free = !op_valid || op_ready;
    assign iss_ready = slot_free && !hazard;
    assign accept    = iss_valid && iss_ready;

    always_comb begin
        rd1_val = '0;
        rd2_val = '0;
        if (iss_rs1_addr != '0) begin
            rd1_val = (wb_valid && wb_addr == iss_rs1_addr) ? wb_data : regs[iss_rs1_addr];
        end
        if (iss_rs2_addr != '0) begin
            rd2_val = (wb_valid && wb_addr == iss_rs2_addr) ? wb_data : regs[iss_rs2_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            state      <= EMPTY;
            rs1        <= '0;
            rs2        <= '0;
            op_rd_addr <= '0;
            op_rd_we   <= 1'b0;
        end else begin
            if (wb_valid) begin
                if (wb_addr != '0) begin
                    regs[wb_addr] <= wb_data;
                end
                busy[wb_addr] <= 1'b0;
            end
            // Placed after the writeback clear so a newly issued owner keeps rd busy.
            if (accept && iss_rd_we && iss_rd_addr != '0) begin
                busy[iss_rd_addr] <= 1'b1;
            end

            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL:  if (!accept && op_ready) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            if (accept) begin
                rs1        <= rd1_val;
                rs2        <= rd2_val;
                op_rd_addr <= iss_rd_addr;
                op_rd_we   <= iss_rd_we;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Randomised plus directed bench: driver models issue/writeback rules, monitor scores the operand slot.
module tb_alu_operand_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rs1_addr, iss_rs2_addr, iss_rd_addr;
    logic        iss_rd_we;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] rs1, rs2;
    logic [4:0]  op_rd_addr;
    logic        op_rd_we;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    alu_operand_regfile #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
        .iss_rd_addr(iss_rd_addr), .iss_rd_we(iss_rd_we),
        .op_valid(op_valid), .op_ready(op_ready),
        .rs1(rs1), .rs2(rs2), .op_rd_addr(op_rd_addr), .op_rd_we(op_rd_we),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    bit          m_pending [32];
    bit          m_full;
    bit          mon_en;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_valid && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    // A register blocks issue if an older op still owes it a result not arriving this cycle.
    function automatic bit m_blocked(input logic [4:0] a);
        return a != 0 && m_pending[a] && !(wb_valid && wb_addr == a);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pending[i] = 1'b0;
        end
        m_full = 1'b0;
        q.delete();
    endtask

    task automatic cycle(input bit v, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd, input bit we, input bit ordy,
                         input bit wbv, input logic [4:0] wba, input logic [31:0] wbd);
        bit exp_rdy;
        bit acc;
        exp_t e;
        @(negedge clk);
        iss_valid = v; iss_rs1_addr = a1; iss_rs2_addr = a2;
        iss_rd_addr = rd; iss_rd_we = we; op_ready = ordy;
        wb_valid = wbv; wb_addr = wba; wb_data = wbd;
        #1;
        exp_rdy = (!m_full || ordy) && !(we && m_blocked(rd)) && !m_blocked(a1) && !m_blocked(a2);
        chk("iss_ready", {31'h0, iss_ready}, {31'h0, exp_rdy});
        acc = v && exp_rdy;
        if (acc) begin
            e.a = m_read(a1); e.b = m_read(a2); e.rd = rd; e.we = we;
            q.push_back(e);
        end
        @(posedge clk);
        if (wbv) begin
            if (wba != 0) m_regs[wba] = wbd;
            m_pending[wba] = 1'b0;
        end
        if (acc && we && rd != 0) m_pending[rd] = 1'b1;
        if (acc) m_full = 1'b1;
        else if (ordy) m_full = 1'b0;
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 0, 0, 0, 0, ordy, 0, 0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; iss_valid = 1'b1; op_ready = 1'b1; wb_valid = 1'b0;
        iss_rs1_addr = 5'd1; iss_rs2_addr = 5'd2; iss_rd_addr = 5'd3; iss_rd_we = 1'b1;
        repeat (n) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1; iss_valid = 1'b0;
        #1;
        chk("rst_op_valid", {31'h0, op_valid}, 32'h0);
        chk("rst_rs1", rs1, 32'h0);
        chk("rst_rs2", rs2, 32'h0);
        chk("rst_rd", {27'h0, op_rd_addr}, 32'h0);
        chk("rst_rd_we", {31'h0, op_rd_we}, 32'h0);
    endtask

    // Monitor: compares the slot against the scoreboard each cycle, pops on consume.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && mon_en) begin
                chk("op_valid", {31'h0, op_valid}, {31'h0, m_full});
                if (m_full) begin
                    if (q.size() == 0) begin
                        chk("sb_nonempty", 32'h0, 32'h1);
                    end else begin
                        chk("op_rs1", rs1, q[0].a);
                        chk("op_rs2", rs2, q[0].b);
                        chk("op_rd_addr", {27'h0, op_rd_addr}, {27'h0, q[0].rd});
                        chk("op_rd_we", {31'h0, op_rd_we}, {31'h0, q[0].we});
                        if (op_ready) void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [4:0] r1, r2, rd, wa;
        logic [31:0] wd;
        bit v, we, ordy, wbv;
        mon_en = 1'b0;
        rst_n = 1'b0; iss_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
        iss_rs1_addr = '0; iss_rs2_addr = '0; iss_rd_addr = '0; iss_rd_we = 1'b0;
        wb_addr = '0; wb_data = '0;
        model_clear();

        do_reset(2);
        mon_en = 1'b1;
        idle(1);

        // write then read
        cycle(0, 0, 0, 0, 0, 1, 1, 5'd1, 32'hFFFF_FFFF);
        cycle(1, 5'd1, 5'd0, 5'd0, 0, 1, 0, 0, 32'h0);
        idle(1);

        // RAW stall released by a bypassed writeback
        cycle(1, 0, 0, 5'd3, 1, 1, 0, 0, 32'h0);
        repeat (3) cycle(1, 5'd3, 0, 5'd4, 0, 1, 0, 0, 32'h0);
        cycle(1, 5'd3, 0, 5'd4, 0, 1, 1, 5'd3, 32'h0000_FFFF);
        idle(1);

        // backpressure then back-to-back
        cycle(1, 5'd1, 5'd3, 5'd6, 0, 1, 0, 0, 32'h0);
        repeat (3) cycle(1, 5'd3, 5'd1, 5'd8, 0, 0, 0, 0, 32'h0);
        cycle(1, 5'd3, 5'd1, 5'd8, 0, 1, 0, 0, 32'h0);
        cycle(1, 5'd1, 5'd1, 5'd9, 0, 1, 0, 0, 32'h0);
        idle(1);

        // x0 writes are dropped and x0 never goes busy
        cycle(1, 0, 0, 0, 1, 1, 1, 5'd0, 32'hFFFF_FFFF);
        cycle(1, 0, 0, 0, 1, 1, 0, 0, 32'h0);
        idle(1);

        // WAW with same-cycle writeback to the same rd
        cycle(1, 0, 0, 5'd5, 1, 1, 0, 0, 32'h0);
        cycle(1, 0, 0, 5'd5, 1, 1, 1, 5'd5, 32'h1234_5678);
        cycle(1, 5'd5, 0, 0, 0, 1, 0, 0, 32'h0);
        cycle(1, 5'd5, 5'd5, 0, 0, 1, 1, 5'd5, 32'hCAFE_0005);
        idle(1);

        // mid-operation reset drops the slot and pending destinations
        cycle(1, 5'd1, 0, 5'd7, 1, 0, 0, 0, 32'h0);
        do_reset(1);
        cycle(1, 5'd7, 5'd1, 5'd7, 1, 1, 0, 0, 32'h0);
        idle(1);

        repeat (600) begin
            v    = ($urandom_range(0, 3) != 0);
            r1   = 5'($urandom_range(0, 7));
            r2   = 5'($urandom_range(0, 7));
            rd   = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            we   = $urandom_range(0, 1) != 0;
            ordy = ($urandom_range(0, 3) != 0);
            wbv  = ($urandom_range(0, 1) != 0);
            wa   = 5'($urandom_range(0, 7));
            wd   = $urandom;
            cycle(v, r1, r2, rd, we, ordy, wbv, wa, wd);
        end

        repeat (4) idle(1);
        chk("sb_drained", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
Register file and operand issue stage on the input side of the ALU function units (alu_xor and related). It accepts instruction register addresses and reads rs1/rs2 values into a registered operand slot for the ALU. It accepts rd writeback from the ALU and tracks pending destinations in a busy scoreboard. Issue stalls on RAW/WAW hazards, and a same-cycle writeback is bypassed to the issue.

Parameters:
XLEN, 32, data width of registers and operands
NREG, 32, number of architectural registers (x0 hardwired to zero)
AW, 5, register address width (log2 NREG)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  synchronous reset, active-low
iss_valid  input  1  issue request present
iss_ready  output  1  issue accepted this cycle when iss_valid && iss_ready
iss_rs1_addr  input  AW  source 1 address
iss_rs2_addr  input  AW  source 2 address
iss_rd_addr  input  AW  destination address
iss_rd_we  input  1  instruction writes rd
op_valid  output  1  operand slot holds a valid entry
op_ready  input  1  ALU consumes slot when op_valid && op_ready
rs1  output  XLEN  operand 1 to ALU
rs2  output  XLEN  operand 2 to ALU
op_rd_addr  output  AW  destination tag travelling with operands
op_rd_we  output  1  destination write enable travelling with operands
wb_valid  input  1  writeback present (always accepted, no backpressure)
wb_addr  input  AW  writeback register
wb_data  input  XLEN  writeback value (ALU rd)

Behaviour:
- Reset (rst_n low at posedge): all registers = 0, busy[] = 0, op_valid = 0, rs1 = rs2 = 0, op_rd_addr = 0, op_rd_we = 0. Reset applied mid-operation discards the operand slot and all pending busy bits.
- x0: reads return 0. Writebacks to x0 are dropped. busy[0] is never set.
- Writeback: when wb_valid is high at posedge, regs[wb_addr] <= wb_data (unless wb_addr = 0) and busy[wb_addr] is cleared. A writeback to a non-busy register still writes.
- Effective busy for the issue check: eff_busy[a] = busy[a] && !(wb_valid && wb_addr == a).
- Hazard: iss_rd_we && eff_busy[rd], or eff_busy[rs1], or eff_busy[rs2]. Address 0 never causes a hazard.
- Slot free: !op_valid || op_ready.
- iss_ready = slot free && no hazard. It is combinational and is independent of iss_valid.
- Issue accept (1-cycle latency): op_valid <= 1. rs1/rs2 <= read value. Read value = wb_data when wb_valid && wb_addr == src && src != 0; otherwise regs[src]. op_rd_addr and op_rd_we are registered along with the operands.
- Scoreboard on accept: if iss_rd_we && rd != 0, busy[rd] <= 1. A same-cycle writeback to the same rd still leaves busy set, because the new owner wins.
- Consume without accept: op_valid <= 0. rs1/rs2/op_rd_* hold their last values.
- Slot states: EMPTY (op_valid = 0) and FULL (op_valid = 1).
  - EMPTY to FULL on accept.
  - FULL to FULL on a consume and accept in the same cycle (back-to-back, one op per cycle).
  - FULL to EMPTY on consume only.
  - FULL holds on !op_ready, with outputs stable.
- Writes are not observed by a read in a later cycle except through the register array. Same-cycle writeback is visible only via the bypass.

Test Plan:
- Reset: drive rst_n = 0 for 2 cycles with iss_valid = 1 -> op_valid = 0, rs1 = rs2 = 0, iss_ready stays 1 after release with no busy bits.
- Write then read: wb x1 = 0xFFFFFFFF, next cycle issue rs1 = x1, rs2 = x0 -> next cycle op_valid = 1, rs1 = 0xFFFFFFFF, rs2 = 0.
- RAW stall: issue rd = x3 (we = 1), then issue rs1 = x3 -> iss_ready = 0 until wb x3 = 0x0000FFFF arrives. In the wb cycle iss_ready = 1 and the next op gives rs1 = 0x0000FFFF (bypass).
- Backpressure: op_ready = 0 with op_valid = 1 -> iss_ready = 0 and rs1/rs2 stable for 3 cycles. op_ready = 1 with iss_valid = 1 -> a new op appears the next cycle with no bubble.
- x0 writes: wb x0 = 0xFFFFFFFF, issue rs1 = x0, rd = x0 with we = 1 -> rs1 = 0, busy[0] stays 0, and a following issue is not stalled.
- WAW and same-cycle event: x5 busy; wb x5 = 0x12345678 in the same cycle as an issue with rd = x5 -> issue accepted, busy[5] = 1 afterwards, regs[5] = 0x12345678.
